// File: rtl/mb_rtu_uart_tx_pkg.sv
// Shared definitions for the Modbus RTU UART transmitter: state encoding,
// parity codes and frame limits.
package mb_rtu_uart_tx_pkg;

  localparam int unsigned PARITY_NONE   = 0;
  localparam int unsigned PARITY_EVEN   = 1;
  localparam int unsigned PARITY_ODD    = 2;
  localparam int unsigned RTU_MAX_FRAME = 256;

  // bit-time counter width; covers GAP_BITS up to 255
  localparam int unsigned BITN_W = 8;

  typedef enum logic [6:0] {
    ST_IDLE  = 7'b0000001,
    ST_LEAD  = 7'b0000010,
    ST_START = 7'b0000100,
    ST_DATA  = 7'b0001000,
    ST_PAR   = 7'b0010000,
    ST_STOP  = 7'b0100000,
    ST_GAP   = 7'b1000000
  } tx_state_e;

  // 11-bit character: no parity uses two stop bits, otherwise one
  function automatic int unsigned stop_bits(input int unsigned parity);
    return (parity == PARITY_NONE) ? 2 : 1;
  endfunction

endpackage

// File: rtl/mb_rtu_uart_tx_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data; a write and a
// read may happen in the same cycle.
module mb_rtu_uart_tx_sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned AW    = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] r_mem [2**AW];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr;
  logic             w_rd;

  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_wr    = wr_en && !full;
  assign w_rd    = rd_en && !empty;
  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

  // storage is not reset; pointers alone define the contents
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/mb_rtu_uart_tx.sv
// Buffers a Modbus RTU byte burst and serialises it as one UART frame with
// RS-485 driver control and the trailing 3.5-character silence.
module mb_rtu_uart_tx
  import mb_rtu_uart_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned PARITY   = 0,
  parameter int unsigned FIFO_AW  = 9,
  parameter int unsigned DE_LEAD  = 1,
  parameter int unsigned GAP_BITS = 39
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mb_tx_en,
  input  logic [7:0] mb_txd,
  output logic       uart_txd,
  output logic       rs485_de,
  output logic       tx_busy,
  output logic       frame_sent,
  output logic       ovf_err
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
  localparam int unsigned BAUD_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BITN_W-1:0] LEAD_LAST = BITN_W'((DE_LEAD > 0) ? DE_LEAD - 1 : 0);
  localparam logic [BITN_W-1:0] DATA_LAST = BITN_W'(7);
  localparam logic [BITN_W-1:0] STOP_LAST = BITN_W'(stop_bits(PARITY) - 1);
  localparam logic [BITN_W-1:0] GAP_LAST  = BITN_W'(GAP_BITS - 1);

  logic              r_in_vld;
  logic [7:0]        r_in_byte;
  logic              r_ovf;
  tx_state_e         r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [BITN_W-1:0] r_bitn;
  logic [7:0]        r_shift;
  logic              r_last;
  logic              r_par;
  logic              r_txd;
  logic              r_de;
  logic              r_busy;
  logic              r_fs;

  logic [8:0]        w_wr_data;
  logic [8:0]        w_rd_data;
  logic              w_full;
  logic              w_empty;
  logic              w_bit_end;
  logic              w_pop;

  // the byte is tagged last when the burst has ended by the time it is written
  assign w_wr_data = {~mb_tx_en, r_in_byte};
  assign w_bit_end = (r_baud == BAUD_LAST);

  mb_rtu_uart_tx_sync_fifo #(
    .WIDTH (9),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (r_in_vld),
    .wr_data (w_wr_data),
    .rd_en   (w_pop),
    .rd_data (w_rd_data),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_vld  <= 1'b0;
      r_in_byte <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_in_vld  <= mb_tx_en;
      r_in_byte <= mb_txd;
      if (r_in_vld && w_full) r_ovf <= 1'b1;
    end
  end

  // every transition into START pops the next character
  assign w_pop = ((r_state == ST_IDLE) && !w_empty && (DE_LEAD == 0)) ||
                 ((r_state == ST_LEAD) && w_bit_end && (r_bitn == LEAD_LAST)) ||
                 ((r_state == ST_STOP) && w_bit_end && (r_bitn == STOP_LAST) &&
                  !r_last && !w_empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bitn  <= '0;
      r_shift <= '0;
      r_last  <= 1'b0;
      r_par   <= 1'b0;
      r_txd   <= 1'b1;
      r_de    <= 1'b0;
      r_busy  <= 1'b0;
      r_fs    <= 1'b0;
    end else begin
      r_fs   <= 1'b0;
      r_baud <= w_bit_end ? '0 : r_baud + BAUD_W'(1);
      case (r_state)
        ST_IDLE: begin
          r_baud <= '0;
          r_bitn <= '0;
          if (!w_empty) begin
            r_de   <= 1'b1;
            r_busy <= 1'b1;
            if (DE_LEAD != 0) r_state <= ST_LEAD;
          end
        end
        ST_LEAD: begin
          if (w_bit_end) r_bitn <= r_bitn + BITN_W'(1);
        end
        ST_START: begin
          if (w_bit_end) begin
            r_state <= ST_DATA;
            r_txd   <= r_shift[0];
            r_par   <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_bitn  <= '0;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            if (r_bitn == DATA_LAST) begin
              r_bitn <= '0;
              if (PARITY != PARITY_NONE) begin
                r_state <= ST_PAR;
                r_txd   <= (PARITY == PARITY_ODD) ? ~r_par : r_par;
              end else begin
                r_state <= ST_STOP;
                r_txd   <= 1'b1;
              end
            end else begin
              r_txd   <= r_shift[0];
              r_par   <= r_par ^ r_shift[0];
              r_shift <= r_shift >> 1;
              r_bitn  <= r_bitn + BITN_W'(1);
            end
          end
        end
        ST_PAR: begin
          if (w_bit_end) begin
            r_state <= ST_STOP;
            r_txd   <= 1'b1;
            r_bitn  <= '0;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            if (r_bitn != STOP_LAST) begin
              r_bitn <= r_bitn + BITN_W'(1);
            end else if (r_last || w_empty) begin
              r_state <= ST_GAP;
              r_de    <= 1'b0;
              r_bitn  <= '0;
            end
          end
        end
        ST_GAP: begin
          if (w_bit_end) begin
            if (r_bitn == GAP_LAST) begin
              r_state <= ST_IDLE;
              r_fs    <= 1'b1;
              r_busy  <= !w_empty;
              r_bitn  <= '0;
            end else begin
              r_bitn <= r_bitn + BITN_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_pop) begin
        r_state <= ST_START;
        r_txd   <= 1'b0;
        r_shift <= w_rd_data[7:0];
        r_last  <= w_rd_data[8];
        r_bitn  <= '0;
        r_baud  <= '0;
      end
    end
  end

  assign uart_txd   = r_txd;
  assign rs485_de   = r_de;
  assign tx_busy    = r_busy;
  assign frame_sent = r_fs;
  assign ovf_err    = r_ovf;

endmodule

// File: tb/tb_mb_rtu_uart_tx.sv
// Self-checking bench for mb_rtu_uart_tx: four instances (no/even/odd parity,
// tiny FIFO) at 16 clk per bit, compared against an expected line waveform.
module tb_mb_rtu_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en   [4];
  logic [7:0] dat  [4];
  logic       txd  [4];
  logic       de   [4];
  logic       busy [4];
  logic       fs   [4];
  logic       ovf  [4];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mb_rtu_uart_tx #(.CLK_FREQ(16), .BAUD(1), .PARITY(0), .FIFO_AW(9), .DE_LEAD(1), .GAP_BITS(39)) u_p0 (
    .clk(clk), .rst_n(rst_n), .mb_tx_en(en[0]), .mb_txd(dat[0]), .uart_txd(txd[0]),
    .rs485_de(de[0]), .tx_busy(busy[0]), .frame_sent(fs[0]), .ovf_err(ovf[0]));
  mb_rtu_uart_tx #(.CLK_FREQ(16), .BAUD(1), .PARITY(1), .FIFO_AW(9), .DE_LEAD(1), .GAP_BITS(39)) u_p1 (
    .clk(clk), .rst_n(rst_n), .mb_tx_en(en[1]), .mb_txd(dat[1]), .uart_txd(txd[1]),
    .rs485_de(de[1]), .tx_busy(busy[1]), .frame_sent(fs[1]), .ovf_err(ovf[1]));
  mb_rtu_uart_tx #(.CLK_FREQ(16), .BAUD(1), .PARITY(2), .FIFO_AW(9), .DE_LEAD(1), .GAP_BITS(39)) u_p2 (
    .clk(clk), .rst_n(rst_n), .mb_tx_en(en[2]), .mb_txd(dat[2]), .uart_txd(txd[2]),
    .rs485_de(de[2]), .tx_busy(busy[2]), .frame_sent(fs[2]), .ovf_err(ovf[2]));
  mb_rtu_uart_tx #(.CLK_FREQ(16), .BAUD(1), .PARITY(0), .FIFO_AW(2), .DE_LEAD(1), .GAP_BITS(39)) u_small (
    .clk(clk), .rst_n(rst_n), .mb_tx_en(en[3]), .mb_txd(dat[3]), .uart_txd(txd[3]),
    .rs485_de(de[3]), .tx_busy(busy[3]), .frame_sent(fs[3]), .ovf_err(ovf[3]));

  task automatic drive_burst(input int idx, input logic [7:0] b[$]);
    foreach (b[i]) begin
      en[idx]  = 1'b1;
      dat[idx] = b[i];
      @(posedge clk); #1;
    end
    en[idx]  = 1'b0;
    dat[idx] = 8'h00;
  endtask

  // Waits for DE to rise, then checks the whole frame: 1 lead bit, 11-bit chars,
  // DE low after the last stop bit, frame_sent exactly 39 bit times later.
  task automatic check_frame(input int idx, input logic [7:0] b[$], input int par,
                             input int exp_de, input logic busy_after, output int end_cyc);
    logic bits[$];
    int   t, c0, data_end, fs_at;
    int   n_txd, n_de, n_fs, n_busy;
    int   f_txd, f_de, f_fs, f_busy;
    logic x_txd, x_de, x_fs, x_busy;
    logic a_txd, a_de, a_fs, a_busy;
    foreach (b[i]) begin
      bits.push_back(1'b0);
      for (int j = 0; j < 8; j++) bits.push_back(b[i][j]);
      if (par == 1) bits.push_back(($countones(b[i]) % 2) == 1);
      if (par == 2) bits.push_back(($countones(b[i]) % 2) == 0);
      bits.push_back(1'b1);
      if (par == 0) bits.push_back(1'b1);
    end
    t = 0;
    do begin @(negedge clk); t++; end while (de[idx] !== 1'b1 && t < 4000);
    total++;
    if (de[idx] !== 1'b1) begin
      bad++;
      $display("FAIL de_rise[%0d]: de=%b after %0d clk, required 1", idx, de[idx], t);
      end_cyc = cyc;
      return;
    end
    c0 = cyc;
    if (exp_de >= 0) begin
      total++;
      if (c0 !== exp_de) begin
        bad++;
        $display("FAIL de_latency[%0d]: de rose at clk %0d, required %0d", idx, c0, exp_de);
      end
    end
    data_end = 16 + 16 * bits.size();
    fs_at    = data_end + 39 * 16;
    n_txd = 0; n_de = 0; n_fs = 0; n_busy = 0;
    f_txd = 0; f_de = 0; f_fs = 0; f_busy = 0;
    a_txd = 0; a_de = 0; a_fs = 0; a_busy = 0;
    x_txd = 0; x_de = 0; x_fs = 0; x_busy = 0;
    for (int r = 0; r <= fs_at; r++) begin
      logic et, ed, ef, eb;
      if (r > 0) @(negedge clk);
      et = (r >= 16 && r < data_end) ? bits[(r - 16) / 16] : 1'b1;
      ed = (r < data_end);
      ef = (r == fs_at);
      eb = (r == fs_at) ? busy_after : 1'b1;
      if (txd[idx] !== et) begin
        if (n_txd == 0) begin f_txd = r; a_txd = txd[idx]; x_txd = et; end
        n_txd++;
      end
      if (de[idx] !== ed) begin
        if (n_de == 0) begin f_de = r; a_de = de[idx]; x_de = ed; end
        n_de++;
      end
      if (fs[idx] !== ef) begin
        if (n_fs == 0) begin f_fs = r; a_fs = fs[idx]; x_fs = ef; end
        n_fs++;
      end
      if (busy[idx] !== eb) begin
        if (n_busy == 0) begin f_busy = r; a_busy = busy[idx]; x_busy = eb; end
        n_busy++;
      end
    end
    total += 4;
    if (n_txd != 0) begin
      bad++;
      $display("FAIL uart_txd[%0d]: %0d wrong clk, first at +%0d got %b required %b", idx, n_txd, f_txd, a_txd, x_txd);
    end
    if (n_de != 0) begin
      bad++;
      $display("FAIL rs485_de[%0d]: %0d wrong clk, first at +%0d got %b required %b", idx, n_de, f_de, a_de, x_de);
    end
    if (n_fs != 0) begin
      bad++;
      $display("FAIL frame_sent[%0d]: %0d wrong clk, first at +%0d got %b required %b", idx, n_fs, f_fs, a_fs, x_fs);
    end
    if (n_busy != 0) begin
      bad++;
      $display("FAIL tx_busy[%0d]: %0d wrong clk, first at +%0d got %b required %b", idx, n_busy, f_busy, a_busy, x_busy);
    end
    end_cyc = cyc;
  endtask

  task automatic send_and_check(input int idx, input logic [7:0] q[$], input int par);
    int k, e;
    @(posedge clk); #1;
    k = cyc;
    fork
      drive_burst(idx, q);
      check_frame(idx, q, par, k + 3, 1'b0, e);
    join
  endtask

  task automatic test_reset;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({txd[i], de[i], busy[i], fs[i], ovf[i]} !== 5'b10000) begin
        bad++;
        $display("FAIL reset_in[%0d]: outputs=%b required 10000", i, {txd[i], de[i], busy[i], fs[i], ovf[i]});
      end
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({txd[i], de[i], busy[i], fs[i], ovf[i]} !== 5'b10000) begin
        bad++;
        $display("FAIL reset_idle[%0d]: outputs=%b required 10000", i, {txd[i], de[i], busy[i], fs[i], ovf[i]});
      end
    end
  endtask

  task automatic test_basic;
    logic [7:0] q[$];
    q = {8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h02, 8'hC4, 8'h0B};
    send_and_check(0, q, 0);
  endtask

  task automatic test_random;
    logic [7:0] q[$];
    for (int n = 0; n < 3; n++) begin
      q = {};
      for (int i = 0; i < int'($urandom_range(1, 8)); i++) q.push_back(8'($urandom));
      send_and_check(0, q, 0);
    end
  endtask

  task automatic test_parity;
    logic [7:0] q[$];
    for (int p = 1; p <= 2; p++) begin
      q = {8'h07};
      send_and_check(p, q, p);
      q = {8'($urandom), 8'($urandom)};
      send_and_check(p, q, p);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    int k, e1, e2;
    q1 = {8'($urandom), 8'($urandom), 8'($urandom)};
    q2 = {8'($urandom), 8'($urandom)};
    @(posedge clk); #1;
    k = cyc;
    fork
      begin
        drive_burst(0, q1);
        repeat (2) @(posedge clk);
        #1;
        drive_burst(0, q2);
      end
      begin
        check_frame(0, q1, 0, k + 3, 1'b1, e1);
        check_frame(0, q2, 0, e1 + 1, 1'b0, e2);
      end
    join
  endtask

  task automatic test_overflow;
    logic [7:0] q6[$];
    logic [7:0] q4[$];
    int k, e, ev;
    for (int i = 0; i < 6; i++) q6.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) q4.push_back(q6[i]);
    total++;
    if (ovf[3] !== 1'b0) begin
      bad++;
      $display("FAIL ovf_pre: ovf_err=%b required 0", ovf[3]);
    end
    @(posedge clk); #1;
    k = cyc;
    fork
      begin
        drive_burst(3, q6);
        total++;
        if (ovf[3] !== 1'b1) begin
          bad++;
          $display("FAIL ovf_set: ovf_err=%b required 1", ovf[3]);
        end
      end
      check_frame(3, q4, 0, k + 3, 1'b0, e);
    join
    ev = 0;
    repeat (200) begin
      @(negedge clk);
      if (fs[3] !== 1'b0 || de[3] !== 1'b0) ev++;
    end
    total += 2;
    if (ev != 0) begin
      bad++;
      $display("FAIL ovf_extra_frame: %0d active clk after frame, required 0", ev);
    end
    if (ovf[3] !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky: ovf_err=%b required 1", ovf[3]);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] q[$];
    int k, ev;
    for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
    @(posedge clk); #1;
    k = cyc;
    drive_burst(0, q);
    while (cyc < k + 3 + 400) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({txd[0], de[0], busy[0], fs[0]} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_mid: txd,de,busy,fs=%b required 1000", {txd[0], de[0], busy[0], fs[0]});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    ev = 0;
    repeat (800) begin
      @(negedge clk);
      if (fs[0] !== 1'b0 || de[0] !== 1'b0 || txd[0] !== 1'b1 || busy[0] !== 1'b0) ev++;
    end
    total++;
    if (ev != 0) begin
      bad++;
      $display("FAIL reset_flush: %0d non-idle clk after reset, required 0", ev);
    end
    q = {8'($urandom), 8'($urandom), 8'($urandom)};
    send_and_check(0, q, 0);
  endtask

  task automatic test_single;
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    int k, e1, e2;
    q1 = {8'hA5};
    q2 = {8'($urandom)};
    @(posedge clk); #1;
    k = cyc;
    fork
      begin
        drive_burst(0, q1);
        repeat (294) @(posedge clk);
        #1;
        drive_burst(0, q2);
      end
      begin
        check_frame(0, q1, 0, k + 3, 1'b1, e1);
        check_frame(0, q2, 0, e1 + 1, 1'b0, e2);
      end
    join
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en[i]  = 1'b0;
      dat[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    test_reset;
    test_basic;
    test_random;
    test_parity;
    test_back_to_back;
    test_overflow;
    test_reset_mid;
    test_single;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached at clk %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
